iagc_controller: RTL and testbench
==================================

Name: iagc_controller

Overview:
- Top-level IAGC status sequencer. Generates the 4-bit IAGC status bus that the watchdog and the rest of the IAGC datapath consume.
- Steps RESET -> INIT -> IDLE -> ARMED -> RUN, with a FAULT state. Transitions depend on the watchdog's gate-valid indication, start/stop commands and timeouts.

Parameters:
- IAGC_STATUS_SIZE, 4, width of the status bus
- INIT_CYCLES, 16, clock cycles spent in INIT before entering IDLE (>=1)
- ARM_TIMEOUT, 64, maximum cycles in ARMED waiting for i_gateValid before FAULT (>=1)
- LOSS_TICKS, 8, consecutive cycles of i_gateValid low in RUN that cause FAULT (>=1)
- CNT_WIDTH, 16, width of o_runCycles

Ports:
- i_clock  in  1  system clock, rising edge
- i_reset  in  1  synchronous, active-low reset
- i_start  in  1  start request, level, sampled only in IDLE
- i_stop  in  1  stop request, level, sampled in ARMED and RUN
- i_clearFault  in  1  fault acknowledge, sampled only in FAULT
- i_gateValid  in  1  o_valid from the watchdog
- o_iagcStatus  out  IAGC_STATUS_SIZE  current state encoding
- o_running  out  1  high while in RUN
- o_fault  out  1  high while in FAULT
- o_faultCode  out  2  00 none, 01 arm timeout, 10 gate loss
- o_runCycles  out  CNT_WIDTH  cycles spent in the current RUN episode

Behaviour:
- State encodings: RESET=0000, INIT=0001, IDLE=0010, ARMED=0011, RUN=0100, FAULT=1111. o_iagcStatus is the registered state (Moore); all outputs are registered.
- Reset, when i_reset=0 at a rising edge:
  - state=RESET, all counters 0, o_running=0, o_fault=0, o_faultCode=00, o_runCycles=0.
  - Reset overrides every other input in any state, including mid-RUN and mid-FAULT.
- RESET: one cycle after reset deasserts -> INIT unconditionally.
- INIT:
  - Internal counter counts 0..INIT_CYCLES-1.
  - On the cycle the count reaches INIT_CYCLES-1 -> IDLE. INIT therefore lasts exactly INIT_CYCLES cycles.
  - All command inputs are ignored in INIT.
- IDLE:
  - i_start=1 -> ARMED next cycle.
  - i_stop is ignored. i_start held high does not re-arm after a stop until IDLE is re-entered.
- ARMED:
  - Priority: i_stop=1 -> IDLE, then i_gateValid=1 -> RUN, then timeout.
  - Timeout: if ARM_TIMEOUT cycles elapse in ARMED without i_gateValid -> FAULT with o_faultCode=01.
  - i_gateValid and the timeout in the same cycle -> RUN; valid wins over timeout.
- RUN:
  - o_runCycles increments every cycle in RUN and saturates at all-ones (no wrap).
  - o_runCycles clears to 0 on RUN entry. It holds its value after leaving RUN until the next RUN entry.
  - Loss counter increments each cycle i_gateValid=0 and clears on any cycle i_gateValid=1.
  - Loss counter reaching LOSS_TICKS -> FAULT with o_faultCode=10.
  - i_stop=1 -> IDLE, with priority over the loss fault in the same cycle.
- FAULT:
  - o_fault=1 and o_faultCode holds its value.
  - i_clearFault=1 -> INIT; o_faultCode clears to 00 on exit.
  - All other inputs are ignored.
- Counters for INIT, ARMED and loss reset to 0 on every state entry.

Optional Feature:
- Macro IAGC_AUTO_RECOVER_EN.
- When defined:
  - Adds parameter RECOVER_CYCLES (default 32).
  - FAULT exits to INIT automatically after RECOVER_CYCLES cycles if i_clearFault has not arrived first.
  - If i_clearFault arrives first, the exit happens earlier, on i_clearFault.
- When undefined: FAULT is exited only by i_clearFault or reset. No recovery counter is synthesized.

Test Plan:
- Reset release, INIT_CYCLES=16 -> o_iagcStatus reads 0000 for 1 cycle, then 0001 for 16 cycles, then 0010. All other outputs are 0.
- In IDLE, pulse i_start, then drive i_gateValid=1 three cycles later -> status 0011 for 3 cycles, then 0100. o_running=1 and o_runCycles counts 1, 2, 3, ...
- Arm with i_gateValid held low, ARM_TIMEOUT=64 -> FAULT (1111) exactly 64 cycles after ARMED entry. o_faultCode=01. Pulse i_clearFault -> INIT, o_faultCode=00.
- In RUN, drop i_gateValid for 7 cycles, restore it, then drop it for 8 cycles -> no fault after the first gap; FAULT with o_faultCode=10 after the 8th low cycle.
- In RUN, assert i_stop on the same cycle the loss counter hits LOSS_TICKS -> IDLE, o_fault stays 0, o_runCycles holds its last value.
- Assert i_reset=0 mid-RUN for 1 cycle -> next state RESET, o_runCycles=0. With IAGC_AUTO_RECOVER_EN and RECOVER_CYCLES=32, a fault with no clear returns to INIT after 32 cycles.

Source files
------------

// File: rtl/iagc_controller.sv
// -----------------------------------------------------------------------------
// iagc_controller
//
// Purpose:
//   Top-level IAGC status sequencer. Steps RESET -> INIT -> IDLE -> ARMED ->
//   RUN and also has a FAULT state. It drives the IAGC status bus that the
//   watchdog and the rest of the IAGC datapath consume. All outputs come
//   straight from flops (Moore). o_iagcStatus is the registered state, so it
//   also serves as the debug view of the FSM.
//
// Optional feature (macro IAGC_AUTO_RECOVER_EN):
//   When the macro is defined, the block gains the parameter RECOVER_CYCLES.
//   FAULT then exits to INIT by itself after RECOVER_CYCLES cycles, unless
//   i_clearFault arrives first. When the macro is undefined, FAULT is left only
//   on i_clearFault or reset, and no recovery counting is built.
//
// Ports:
//   i_clock        system clock, rising edge
//   i_reset        synchronous, active-low reset
//   i_start        start request (level), sampled only in IDLE
//   i_stop         stop request (level), sampled in ARMED and RUN
//   i_clearFault   fault acknowledge, sampled only in FAULT
//   i_gateValid    o_valid from the watchdog
//   o_iagcStatus   current state encoding
//   o_running      high while in RUN
//   o_fault        high while in FAULT
//   o_faultCode    00 none, 01 arm timeout, 10 gate loss
//   o_runCycles    cycles spent in the current (or last) RUN episode
//
// Handshake note: this block has no valid/ready pairs. i_start, i_stop,
// i_clearFault and i_gateValid are plain levels, sampled on each rising edge
// only in the states listed above.
// -----------------------------------------------------------------------------
module iagc_controller #(
  parameter int IAGC_STATUS_SIZE = 4,
  parameter int INIT_CYCLES      = 16,
  parameter int ARM_TIMEOUT      = 64,
  parameter int LOSS_TICKS       = 8,
  parameter int CNT_WIDTH        = 16
`ifdef IAGC_AUTO_RECOVER_EN
  ,
  parameter int RECOVER_CYCLES   = 32
`endif
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic                        i_stop,
  input  logic                        i_clearFault,
  input  logic                        i_gateValid,
  output logic [IAGC_STATUS_SIZE-1:0] o_iagcStatus,
  output logic                        o_running,
  output logic                        o_fault,
  output logic [1:0]                  o_faultCode,
  output logic [CNT_WIDTH-1:0]        o_runCycles
);

  typedef enum logic [3:0] {
    ST_RESET = 4'b0000,
    ST_INIT  = 4'b0001,
    ST_IDLE  = 4'b0010,
    ST_ARMED = 4'b0011,
    ST_RUN   = 4'b0100,
    ST_FAULT = 4'b1111
  } state_e;

  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_ARM_TO   = 2'b01;
  localparam logic [1:0] CODE_GATELOSS = 2'b10;

  // The phase counter is shared by INIT, ARMED and (optionally) FAULT. Only
  // one of these states is active at a time, and the counter clears on every
  // state entry. It only has to reach the largest terminal count minus one.
`ifdef IAGC_AUTO_RECOVER_EN
  localparam int T_MAX0 = (INIT_CYCLES > ARM_TIMEOUT) ? INIT_CYCLES : ARM_TIMEOUT;
  localparam int T_MAX  = (T_MAX0 > RECOVER_CYCLES) ? T_MAX0 : RECOVER_CYCLES;
`else
  localparam int T_MAX  = (INIT_CYCLES > ARM_TIMEOUT) ? INIT_CYCLES : ARM_TIMEOUT;
`endif
  localparam int TW = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int LW = (LOSS_TICKS > 1) ? $clog2(LOSS_TICKS) : 1;

  localparam logic [TW-1:0] INIT_LAST = TW'(INIT_CYCLES - 1);
  localparam logic [TW-1:0] ARM_LAST  = TW'(ARM_TIMEOUT - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_TICKS - 1);
`ifdef IAGC_AUTO_RECOVER_EN
  localparam logic [TW-1:0] REC_LAST  = TW'(RECOVER_CYCLES - 1);
`endif

  state_e               state_q, state_d;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic [LW-1:0]        loss_q, loss_d;
  logic [1:0]           code_q, code_d;
  logic [CNT_WIDTH-1:0] run_cycles_q, run_cycles_d;
  logic                 running_q, running_d;
  logic                 fault_q, fault_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    loss_d       = loss_q;
    code_d       = code_q;
    run_cycles_d = run_cycles_q;

    case (state_q)
      ST_RESET: state_d = ST_INIT;

      ST_INIT: begin
        cnt_d = cnt_q + TW'(1);
        if (cnt_q == INIT_LAST) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        if (i_start) state_d = ST_ARMED;
      end

      // Stop wins over gate-valid, and gate-valid wins over the timeout.
      ST_ARMED: begin
        cnt_d = cnt_q + TW'(1);
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if (i_gateValid) begin
          state_d = ST_RUN;
        end else if (cnt_q == ARM_LAST) begin
          state_d = ST_FAULT;
          code_d  = CODE_ARM_TO;
        end
      end

      // loss_q counts the consecutive low cycles already seen. The current
      // low cycle is the LOSS_TICKS-th one when loss_q sits at LOSS_LAST.
      ST_RUN: begin
        if (i_gateValid) loss_d = '0;
        else             loss_d = loss_q + LW'(1);
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if (!i_gateValid && (loss_q == LOSS_LAST)) begin
          state_d = ST_FAULT;
          code_d  = CODE_GATELOSS;
        end
      end

      ST_FAULT: begin
`ifdef IAGC_AUTO_RECOVER_EN
        cnt_d = cnt_q + TW'(1);
        if (i_clearFault || (cnt_q == REC_LAST)) state_d = ST_INIT;
`else
        if (i_clearFault) state_d = ST_INIT;
`endif
      end

      default: state_d = ST_RESET;
    endcase

    // Every state entry starts the counters afresh.
    if (state_d != state_q) begin
      cnt_d  = '0;
      loss_d = '0;
    end

    // The clear on RUN entry and the count for that first RUN cycle are
    // merged into one step, so the first RUN cycle reads 1. On exit from
    // RUN the counter is frozen until the next entry.
    if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
      run_cycles_d = CNT_WIDTH'(1);
    end else if ((state_d == ST_RUN) && (run_cycles_q != {CNT_WIDTH{1'b1}})) begin
      run_cycles_d = run_cycles_q + CNT_WIDTH'(1);
    end

    if (state_d != ST_FAULT) code_d = CODE_NONE;

    running_d = (state_d == ST_RUN);
    fault_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q      <= ST_RESET;
      cnt_q        <= '0;
      loss_q       <= '0;
      code_q       <= CODE_NONE;
      run_cycles_q <= '0;
      running_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      loss_q       <= loss_d;
      code_q       <= code_d;
      run_cycles_q <= run_cycles_d;
      running_q    <= running_d;
      fault_q      <= fault_d;
    end
  end

  assign o_iagcStatus = IAGC_STATUS_SIZE'(state_q);
  assign o_running    = running_q;
  assign o_fault      = fault_q;
  assign o_faultCode  = code_q;
  assign o_runCycles  = run_cycles_q;

endmodule

// File: tb/tb_iagc_controller.sv
// -----------------------------------------------------------------------------
// tb_iagc_controller
//
// Directed bench for iagc_controller, run with the default parameters.
// Inputs change 1 time unit after a rising edge. Outputs are checked at the
// same point, well away from the next active edge. Expected values are worked
// out by hand from the state sequence.
// -----------------------------------------------------------------------------
module tb_iagc_controller;

  logic        i_clock;
  logic        i_reset;
  logic        i_start;
  logic        i_stop;
  logic        i_clearFault;
  logic        i_gateValid;
  logic [3:0]  o_iagcStatus;
  logic        o_running;
  logic        o_fault;
  logic [1:0]  o_faultCode;
  logic [15:0] o_runCycles;

  int n_cmp;
  int n_fail;

  iagc_controller dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_clearFault (i_clearFault),
    .i_gateValid  (i_gateValid),
    .o_iagcStatus (o_iagcStatus),
    .o_running    (o_running),
    .o_fault      (o_fault),
    .o_faultCode  (o_faultCode),
    .o_runCycles  (o_runCycles)
  );

  // ---------------- clock ----------------
  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // Walks INIT (first cycle already showing) through to IDLE.
  task automatic finish_init();
    for (int i = 0; i < 16; i++) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_reset = 1'b0; i_start = 1'b0; i_stop = 1'b0;
    i_clearFault = 1'b0; i_gateValid = 1'b0;
    tick(); tick();
    n_cmp++;
    if (o_iagcStatus !== 4'b0000 || o_running !== 1'b0 || o_fault !== 1'b0 ||
        o_faultCode !== 2'b00 || o_runCycles !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: status=%b run=%b flt=%b code=%b cyc=%0d expected 0000/0/0/00/0",
               o_iagcStatus, o_running, o_fault, o_faultCode, o_runCycles);
    end
    i_reset = 1'b1;
    n_cmp++;
    if (o_iagcStatus !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_hold_cycle: status=%b expected 0000", o_iagcStatus);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      n_cmp++;
      if (o_iagcStatus !== 4'b0001 || o_running !== 1'b0 || o_fault !== 1'b0) begin
        n_fail++;
        $display("FAIL init_cycle%0d: status=%b run=%b flt=%b expected 0001/0/0",
                 i, o_iagcStatus, o_running, o_fault);
      end
    end
    tick();
    n_cmp++;
    if (o_iagcStatus !== 4'b0010 || o_faultCode !== 2'b00 || o_runCycles !== 16'd0) begin
      n_fail++;
      $display("FAIL idle_after_init: status=%b code=%b cyc=%0d expected 0010/00/0",
               o_iagcStatus, o_faultCode, o_runCycles);
    end
  endtask

  // IDLE: stop is ignored. Start arms, valid in the third ARMED cycle runs.
  task automatic test_run();
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    n_cmp++;
    if (o_iagcStatus !== 4'b0010) begin
      n_fail++;
      $display("FAIL idle_ignores_stop: status=%b expected 0010", o_iagcStatus);
    end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (o_iagcStatus !== 4'b0011 || o_running !== 1'b0) begin
        n_fail++;
        $display("FAIL armed_cycle%0d: status=%b run=%b expected 0011/0", i, o_iagcStatus, o_running);
      end
      if (i == 2) i_gateValid = 1'b1;
      tick();
    end
    for (int k = 1; k <= 3; k++) begin
      n_cmp++;
      if (o_iagcStatus !== 4'b0100 || o_running !== 1'b1 || o_runCycles !== 16'(k)) begin
        n_fail++;
        $display("FAIL run_count%0d: status=%b run=%b cyc=%0d expected 0100/1/%0d",
                 k, o_iagcStatus, o_running, o_runCycles, k);
      end
      if (k < 3) tick();
    end
  endtask

  // Continues in RUN with o_runCycles at 3: a 7-cycle gap is survived, an
  // 8-cycle gap faults.
  task automatic test_gate_loss();
    i_gateValid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    n_cmp++;
    if (o_iagcStatus !== 4'b0100 || o_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL loss_gap7: status=%b flt=%b expected 0100/0", o_iagcStatus, o_fault);
    end
    i_gateValid = 1'b1;
    tick();
    i_gateValid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++;
      if (o_iagcStatus !== 4'b0100) begin
        n_fail++;
        $display("FAIL loss_second_gap%0d: status=%b expected 0100", i, o_iagcStatus);
      end
    end
    tick();
    n_cmp++;
    if (o_iagcStatus !== 4'b1111 || o_fault !== 1'b1 || o_faultCode !== 2'b10 ||
        o_running !== 1'b0 || o_runCycles !== 16'd18) begin
      n_fail++;
      $display("FAIL loss_fault: status=%b flt=%b code=%b run=%b cyc=%0d expected 1111/1/10/0/18",
               o_iagcStatus, o_fault, o_faultCode, o_running, o_runCycles);
    end
    i_clearFault = 1'b1;
    tick();
    i_clearFault = 1'b0;
    n_cmp++;
    if (o_iagcStatus !== 4'b0001 || o_fault !== 1'b0 || o_faultCode !== 2'b00) begin
      n_fail++;
      $display("FAIL loss_clear: status=%b flt=%b code=%b expected 0001/0/00",
               o_iagcStatus, o_fault, o_faultCode);
    end
    finish_init();
  endtask

  // ARMED with valid low times out after exactly 64 cycles. FAULT ignores
  // start/stop/valid. Clear returns to INIT.
  task automatic test_arm_timeout();
    i_gateValid = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (o_iagcStatus !== 4'b0011) begin
        n_fail++;
        $display("FAIL arm_wait%0d: status=%b expected 0011", i, o_iagcStatus);
      end
      tick();
    end
    n_cmp++;
    if (o_iagcStatus !== 4'b1111 || o_fault !== 1'b1 || o_faultCode !== 2'b01) begin
      n_fail++;
      $display("FAIL arm_timeout: status=%b flt=%b code=%b expected 1111/1/01",
               o_iagcStatus, o_fault, o_faultCode);
    end
    i_start = 1'b1; i_stop = 1'b1; i_gateValid = 1'b1;
    tick(); tick(); tick();
    i_start = 1'b0; i_stop = 1'b0; i_gateValid = 1'b0;
    n_cmp++;
    if (o_iagcStatus !== 4'b1111 || o_faultCode !== 2'b01) begin
      n_fail++;
      $display("FAIL fault_ignores_inputs: status=%b code=%b expected 1111/01", o_iagcStatus, o_faultCode);
    end
    i_clearFault = 1'b1;
    tick();
    i_clearFault = 1'b0;
    n_cmp++;
    if (o_iagcStatus !== 4'b0001 || o_faultCode !== 2'b00 || o_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL arm_clear: status=%b code=%b flt=%b expected 0001/00/0",
               o_iagcStatus, o_faultCode, o_fault);
    end
    finish_init();
  endtask

  // Valid and timeout in the same cycle: valid wins.
  task automatic test_valid_beats_timeout();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 63; i++) tick();
    i_gateValid = 1'b1;
    tick();
    n_cmp++;
    if (o_iagcStatus !== 4'b0100 || o_runCycles !== 16'd1 || o_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_beats_timeout: status=%b cyc=%0d flt=%b expected 0100/1/0",
               o_iagcStatus, o_runCycles, o_fault);
    end
    // Stop from RUN with valid high returns to IDLE.
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    n_cmp++;
    if (o_iagcStatus !== 4'b0010 || o_runCycles !== 16'd1 || o_running !== 1'b0) begin
      n_fail++;
      $display("FAIL run_stop: status=%b cyc=%0d run=%b expected 0010/1/0",
               o_iagcStatus, o_runCycles, o_running);
    end
  endtask

  // Stop beats valid in ARMED.
  task automatic test_armed_stop();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_stop = 1'b1; i_gateValid = 1'b1;
    tick();
    i_stop = 1'b0; i_gateValid = 1'b0;
    n_cmp++;
    if (o_iagcStatus !== 4'b0010 || o_running !== 1'b0) begin
      n_fail++;
      $display("FAIL armed_stop: status=%b run=%b expected 0010/0", o_iagcStatus, o_running);
    end
  endtask

  // Stop on the same cycle as the 8th low cycle: IDLE with no fault, and
  // o_runCycles frozen.
  task automatic test_stop_beats_loss();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_gateValid = 1'b1;
    tick();
    i_gateValid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    n_cmp++;
    if (o_iagcStatus !== 4'b0010 || o_fault !== 1'b0 || o_faultCode !== 2'b00 ||
        o_runCycles !== 16'd8) begin
      n_fail++;
      $display("FAIL stop_beats_loss: status=%b flt=%b code=%b cyc=%0d expected 0010/0/00/8",
               o_iagcStatus, o_fault, o_faultCode, o_runCycles);
    end
    tick(); tick();
    n_cmp++;
    if (o_runCycles !== 16'd8) begin
      n_fail++;
      $display("FAIL runcycles_hold: cyc=%0d expected 8", o_runCycles);
    end
  endtask

  // Reset pulse mid-RUN.
  task automatic test_reset_mid_run();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_gateValid = 1'b1;
    tick(); tick();
    i_reset = 1'b0;
    tick();
    i_reset = 1'b1;
    n_cmp++;
    if (o_iagcStatus !== 4'b0000 || o_runCycles !== 16'd0 || o_running !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run: status=%b cyc=%0d run=%b expected 0000/0/0",
               o_iagcStatus, o_runCycles, o_running);
    end
    i_gateValid = 1'b0;
    tick();
    n_cmp++;
    if (o_iagcStatus !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_to_init: status=%b expected 0001", o_iagcStatus);
    end
    finish_init();
  endtask

  // FAULT with no clear: leaves after 32 cycles with auto recovery, and
  // otherwise stays put.
  task automatic test_fault_no_clear();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 64; i++) tick();
`ifdef IAGC_AUTO_RECOVER_EN
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (o_iagcStatus !== 4'b1111) begin
        n_fail++;
        $display("FAIL recover_wait%0d: status=%b expected 1111", i, o_iagcStatus);
      end
      tick();
    end
    n_cmp++;
    if (o_iagcStatus !== 4'b0001 || o_faultCode !== 2'b00) begin
      n_fail++;
      $display("FAIL auto_recover: status=%b code=%b expected 0001/00", o_iagcStatus, o_faultCode);
    end
    finish_init();
`else
    for (int i = 0; i < 100; i++) tick();
    n_cmp++;
    if (o_iagcStatus !== 4'b1111 || o_faultCode !== 2'b01) begin
      n_fail++;
      $display("FAIL fault_sticky: status=%b code=%b expected 1111/01", o_iagcStatus, o_faultCode);
    end
    i_clearFault = 1'b1;
    tick();
    i_clearFault = 1'b0;
    finish_init();
`endif
    n_cmp++;
    if (o_iagcStatus !== 4'b0010) begin
      n_fail++;
      $display("FAIL back_to_idle: status=%b expected 0010", o_iagcStatus);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_run();
    test_gate_loss();
    test_arm_timeout();
    test_valid_beats_timeout();
    test_armed_stop();
    test_stop_beats_loss();
    test_reset_mid_run();
    test_fault_no_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
